// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types for the memory-port arbiter and its users.
//   arb_state_t : ownership state of the single memory port
//   bus_req_t   : one memory access as presented by a master (addr/wr/byt/wdata)
//   ADDR_WIDTH  : system memory address width (byte address)
//   DATA_WIDTH  : memory data width
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ARB_CPU   = 2'd0,   // CPU owns the port, not stalled
      ARB_HAND  = 2'd1,   // CPU read data returns, CPU frozen
      ARB_DMA   = 2'd2,   // DMA owns the port
      ARB_DRAIN = 2'd3    // last DMA read returns, CPU address re-presented
   } arb_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  wr;
      logic                  byt;
      logic [DATA_WIDTH-1:0] wdata;
   } bus_req_t;

   // Builds a request record from the individual master signals.
   function automatic bus_req_t make_req(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic                  wr,
                                         input logic                  byt,
                                         input logic [DATA_WIDTH-1:0] wdata);
      bus_req_t r;
      r.addr  = addr;
      r.wr    = wr;
      r.byt   = byt;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single memory port between the CPU (default owner) and one
// secondary master (DMA / program loader). The CPU is frozen via cpu_stall
// while the DMA owns the port. A HAND cycle lets the CPU's in-flight read
// return before the DMA takes over, a DRAIN cycle lets the last DMA read
// return before the CPU gets the port back, and bursts are capped at
// MAX_BURST accesses so the CPU always gets at least one unstalled cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   cpu_addr/wr/byt/wdata    CPU access request
//   cpu_rdata, cpu_stall     read data to CPU, CPU clock-enable (inverted)
//   dma_req/wr/byt/addr/wdata DMA access request (req held until dma_ack)
//   dma_ack                  access issued this cycle
//   dma_rvalid, dma_rdata    read data, cycle after a read's dma_ack
//   mem_addr/wr/byt/wdata    to memory / peripheral decode
//   mem_rdata                from memory, fixed 1-cycle read latency
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_wr,
   input  logic                  cpu_byt,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dma_req,
   input  logic                  dma_wr,
   input  logic                  dma_byt,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic                  dma_rvalid,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wr,
   output logic                  mem_byt,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int               CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  cpu_own_q, cpu_own_d;   // previous access belonged to the CPU
   logic                  rvalid_q, rvalid_d;

   bus_req_t cpu_bus;
   bus_req_t dma_bus;
   bus_req_t mem_bus;
   logic     ack;
   logic     stall;

   always_comb begin
      cpu_bus = make_req(cpu_addr, cpu_wr, cpu_byt, cpu_wdata);
      dma_bus = make_req(dma_addr, dma_wr, dma_byt, dma_wdata);
   end

   // Next-state, burst counter, hold register and port mux.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      hold_d      = hold_q;
      mem_bus     = cpu_bus;
      ack         = 1'b0;
      stall       = 1'b0;

      case (state_q)
         ARB_CPU: begin
            burst_cnt_d = '0;
            // Entering CPU always costs one unstalled cycle before HAND,
            // so the CPU cannot be starved even if dma_req never drops.
            if (dma_req) begin
               state_d = ARB_HAND;
            end
         end

         ARB_HAND: begin
            stall      = 1'b1;
            mem_bus.wr = 1'b0;          // frozen CPU must not repeat a write
            hold_d     = mem_rdata;     // answer to the CPU's last access
            state_d    = ARB_DMA;
         end

         ARB_DMA: begin
            stall   = 1'b1;
            mem_bus = dma_bus;
            if (dma_req) begin
               ack = 1'b1;
               if (burst_cnt_q != CNT_MAX) begin
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
               end
               if (burst_cnt_q >= CNT_LAST) begin
                  state_d = ARB_DRAIN;
               end
            end else begin
               mem_bus.wr = 1'b0;       // idle DMA slot, no access issued
               state_d    = ARB_DRAIN;
            end
         end

         ARB_DRAIN: begin
            stall       = 1'b1;
            mem_bus.wr  = 1'b0;
            burst_cnt_d = '0;
            state_d     = ARB_CPU;
         end

         default: begin
            state_d = ARB_CPU;
         end
      endcase

      rvalid_d  = ack & ~dma_wr;
      cpu_own_d = (state_q == ARB_CPU);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ARB_CPU;
         burst_cnt_q <= '0;
         hold_q      <= '0;
         cpu_own_q   <= 1'b0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         hold_q      <= hold_d;
         cpu_own_q   <= cpu_own_d;
         rvalid_q    <= rvalid_d;
      end
   end

   // Reset takes effect on the outputs in the reset cycle itself: no write,
   // no ack and no pending read-valid may escape while rst is low.
   always_comb begin
      mem_addr   = mem_bus.addr;
      mem_byt    = mem_bus.byt;
      mem_wdata  = mem_bus.wdata;
      mem_wr     = mem_bus.wr & rst;
      dma_ack    = ack & rst;
      dma_rvalid = rvalid_q & rst;
      cpu_stall  = stall & rst;
      dma_rdata  = mem_rdata;
      // The CPU only sees live memory data when it owned the previous
      // access; otherwise it keeps the word captured in HAND.
      cpu_rdata  = cpu_own_q ? mem_rdata : hold_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
   import bus_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_wr;
   logic                  cpu_byt;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_stall;
   logic                  dma_req;
   logic                  dma_wr;
   logic                  dma_byt;
   logic [ADDR_WIDTH-1:0] dma_addr;
   logic [DATA_WIDTH-1:0] dma_wdata;
   logic                  dma_ack;
   logic                  dma_rvalid;
   logic [DATA_WIDTH-1:0] dma_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr;
   logic                  mem_byt;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_mis = 0;
   int groups [0:7];
   int ng;
   int rel_wr_cnt;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_BURST(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_addr   (cpu_addr),
      .cpu_wr     (cpu_wr),
      .cpu_byt    (cpu_byt),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_wr     (dma_wr),
      .dma_byt    (dma_byt),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_ack    (dma_ack),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_byt    (mem_byt),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Unwritten words read as 0xC000 + word index.
   function automatic logic [15:0] pat(input int i);
      return 16'hC000 + 16'(i);
   endfunction

   // Memory model: word array, byte lanes, 1-cycle read latency, read-old.
   logic [15:0] mem     [0:1023];
   bit          wr_flag [0:1023] = '{default: 1'b0};
   int          wr_cnt  [0:1023] = '{default: 0};
   logic [9:0]  midx;
   logic [15:0] cur;
   assign midx = mem_addr[10:1];

   always @(posedge clk) begin
      cur = wr_flag[midx] ? mem[midx] : pat(int'(midx));
      if (mem_wr) begin
         if (mem_byt && mem_addr[0])      mem[midx] <= {mem_wdata[15:8], cur[7:0]};
         else if (mem_byt)                mem[midx] <= {cur[15:8], mem_wdata[7:0]};
         else                             mem[midx] <= mem_wdata;
         wr_flag[midx] <= 1'b1;
         wr_cnt[midx]  <= wr_cnt[midx] + 1;
      end
      mem_rdata <= cur;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs n DMA accesses starting in a CPU-owned cycle. Checks ack latency,
   // ack addresses, read data, absence of writes in non-ack stalled cycles and
   // that the CPU sees cpu_exp from the first stalled cycle to the release.
   task automatic run_dma(input int n, input logic wr, input logic [15:0] base,
                          input logic [15:0] wbase, input logic [15:0] cpu_exp);
      int k;
      int rv;
      int grp;
      bit seen_stall;
      bit done;
      k = 0; rv = 0; grp = 0; ng = 0; seen_stall = 0; done = 0;
      dma_req = 1'b1; dma_wr = wr; dma_byt = 1'b0; dma_addr = base; dma_wdata = wbase;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            chk("req_cycle_no_ack", dma_ack, 0);
            chk("req_cycle_no_stall", cpu_stall, 0);
         end
         if (cyc == 1) begin
            chk("hand_no_ack", dma_ack, 0);
            chk("hand_stall", cpu_stall, 1);
         end
         if (cyc == 2) chk("first_ack_latency", dma_ack, 1);
         if (cpu_stall || seen_stall) chk("cpu_rdata_held", cpu_rdata, cpu_exp);
         if (dma_rvalid) begin
            chk("dma_rdata", dma_rdata, pat(int'(base >> 1) + rv));
            rv++;
         end
         if (dma_ack) begin
            $display("dma ack %0d addr=%h wr=%b", k, mem_addr, mem_wr);
            chk("ack_mem_addr", mem_addr, base + 16'(2 * k));
            chk("ack_mem_wr", mem_wr, wr);
            k++;
            grp++;
         end else if (cpu_stall) begin
            chk("no_wr_in_stall", mem_wr, 0);
         end
         if (cpu_stall) begin
            seen_stall = 1;
         end else if (grp > 0) begin
            if (ng < 8) groups[ng] = grp;
            ng++;
            grp = 0;
         end
         if (k == n && rv == (wr ? 0 : n) && !cpu_stall && seen_stall) begin
            done = 1;
            rel_wr_cnt = wr_cnt[cpu_addr[10:1]];
         end
         @(posedge clk); #1;
         if (k >= n) begin
            dma_req = 1'b0;
         end else begin
            dma_addr  = base + 16'(2 * k);
            dma_wdata = wbase + 16'(k);
         end
      end
      chk("dma_run_done", done, 1);
      chk("dma_ack_count", k, n);
      chk("dma_rvalid_count", rv, wr ? 0 : n);
   endtask

   initial begin
      int k;
      rst = 1'b0;
      cpu_addr = 16'h03FE; cpu_wr = 1'b1; cpu_byt = 1'b0; cpu_wdata = 16'hDEAD;
      dma_req = 1'b1; dma_wr = 1'b1; dma_byt = 1'b0; dma_addr = 16'h0300; dma_wdata = 16'h1111;

      // Reset held 3 cycles with dma_req and a CPU write pending.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_stall", cpu_stall, 0);
         chk("rst_ack", dma_ack, 0);
         chk("rst_mem_wr", mem_wr, 0);
         chk("rst_rvalid", dma_rvalid, 0);
      end
      @(posedge clk); #1;
      rst = 1'b1; dma_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0100;
      chk("rst_no_write", wr_cnt[16'h03FE >> 1], 0);

      // Plain CPU read of 0x100.
      @(posedge clk); #1;
      @(negedge clk);
      chk("cpu_read_0x100", cpu_rdata, 16'hC080);

      // Single DMA write 0x1234 @0x300 while the CPU reads 0x100.
      @(posedge clk); #1;
      run_dma(1, 1'b1, 16'h0300, 16'h1234, 16'hC080);
      chk("single_groups", ng, 1);
      chk("single_group0", groups[0], 1);
      cpu_addr = 16'h0300;
      @(negedge clk);
      chk("after_release_0x100", cpu_rdata, 16'hC080);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cpu_reads_dma_write", cpu_rdata, 16'h1234);
      chk("dma_write_once", wr_cnt[16'h0300 >> 1], 1);

      // 20-word DMA read burst: groups of 8, 8, 4.
      @(posedge clk); #1;
      cpu_addr = 16'h0100;
      @(posedge clk); #1;
      run_dma(20, 1'b0, 16'h0200, 16'h0000, 16'hC080);
      chk("burst_groups", ng, 3);
      chk("burst_group0", groups[0], 8);
      chk("burst_group1", groups[1], 8);
      chk("burst_group2", groups[2], 4);

      // CPU read 0x0102 issued in the cycle before HAND.
      cpu_addr = 16'h0102;
      run_dma(2, 1'b0, 16'h0240, 16'h0000, 16'hC081);
      @(negedge clk);
      chk("hold_after_release", cpu_rdata, 16'hC081);

      // CPU write at the stall boundary; frozen CPU keeps presenting it.
      @(posedge clk); #1;
      cpu_addr = 16'h0110; cpu_wr = 1'b1; cpu_wdata = 16'hBEEF;
      run_dma(1, 1'b0, 16'h0250, 16'h0000, 16'hC088);
      chk("boundary_write_once", rel_wr_cnt, 1);
      cpu_wr = 1'b0;
      @(negedge clk);
      chk("boundary_write_data", cpu_rdata, 16'hBEEF);

      // Reset mid-burst after 3 acks (write, write, read); 4th is a write.
      @(posedge clk); #1;
      cpu_addr = 16'h0100;
      dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0260; dma_wdata = 16'h7000;
      k = 0;
      for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
         @(negedge clk);
         if (dma_ack) k++;
         @(posedge clk); #1;
         case (k)
            1: begin dma_addr = 16'h0262; dma_wdata = 16'h7001; end
            2: begin dma_wr = 1'b0; dma_addr = 16'h0264; end
            3: begin dma_wr = 1'b1; dma_addr = 16'h0266; dma_wdata = 16'h7003; end
            default: ;
         endcase
      end
      chk("midrst_acks", k, 3);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ack", dma_ack, 0);
      chk("midrst_rvalid", dma_rvalid, 0);
      chk("midrst_mem_wr", mem_wr, 0);
      @(posedge clk); #1;
      rst = 1'b1; dma_req = 1'b0;
      @(negedge clk);
      chk("midrst_stall_next", cpu_stall, 0);
      chk("midrst_ack_next", dma_ack, 0);
      chk("midrst_rvalid_next", dma_rvalid, 0);
      chk("midrst_w0", wr_cnt[16'h0260 >> 1], 1);
      chk("midrst_w1", wr_cnt[16'h0262 >> 1], 1);
      chk("midrst_untouched", wr_cnt[16'h0266 >> 1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
